// File: rtl/pmp_csr_regs.sv
// PMP CSR state: pmpcfg0 plus pmpaddr0..3 with WARL legalisation, lock handling,
// a registered CSR read port and a registered per-entry NAPOT/NA4 byte mask.
module pmp_csr_regs #(
    parameter int          NUM_ENTRIES   = 4,
    parameter logic [11:0] CFG_CSR       = 12'h3A0,
    parameter logic [11:0] ADDR_CSR_BASE = 12'h3B0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      csr_wen,
    input  logic                      csr_ren,
    input  logic [11:0]               csr_addr,
    input  logic [31:0]               csr_wdata,
    output logic                      csr_hit,
    output logic                      csr_rvalid,
    output logic [31:0]               csr_rdata,
    output logic [NUM_ENTRIES-1:0]    pmp_l,
    output logic [2*NUM_ENTRIES-1:0]  pmp_a,
    output logic [NUM_ENTRIES-1:0]    pmp_x,
    output logic [NUM_ENTRIES-1:0]    pmp_w,
    output logic [NUM_ENTRIES-1:0]    pmp_r,
    output logic [30*NUM_ENTRIES-1:0] pmp_addr,
    output logic [32*NUM_ENTRIES-1:0] pmp_mask,
    output logic                      pmp_stable
);
    localparam logic [1:0] A_TOR   = 2'd1;
    localparam logic [1:0] A_NAPOT = 2'd3;

    logic [7:0]  r_cfg  [NUM_ENTRIES];
    logic [29:0] r_addr [NUM_ENTRIES];
    logic [31:0] r_mask [NUM_ENTRIES];
    logic        r_stable;
    logic        r_rvalid;
    logic [31:0] r_rdata;

    logic                   w_cfgSel;
    logic [NUM_ENTRIES-1:0] w_addrSel;
    logic [NUM_ENTRIES-1:0] w_torLock;
    logic [NUM_ENTRIES-1:0] w_cfgWe;
    logic [NUM_ENTRIES-1:0] w_addrWe;
    logic [31:0]            w_readData;

    // Bits 6:5 are hardwired zero and the reserved W=1/R=0 combination drops W.
    function automatic logic [7:0] legalizeCfg(input logic [7:0] b);
        return {b[7], 2'b00, b[4:3], b[2], b[1] & b[0], b[0]};
    endfunction

    // Carries only ripple upward, so the low 30 bits of the trailing-ones run
    // depend only on the low 30 bits of {addr, napot}.
    function automatic logic [31:0] napotMask(input logic [28:0] addrLow, input logic isNapot);
        logic [29:0] t;
        logic [29:0] m;
        t = {addrLow, isNapot};
        m = t & ~(t + 30'd1);
        return {m, 2'b11};
    endfunction

    always_comb begin
        w_cfgSel = (csr_addr == CFG_CSR);
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_addrSel[i] = (csr_addr == ADDR_CSR_BASE + 12'(i));
        end
        csr_hit = w_cfgSel | (|w_addrSel);
    end

    // An entry configured as locked TOR also freezes the address below it.
    always_comb begin
        w_torLock = '0;
        for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
            w_torLock[i] = r_cfg[i+1][7] && (r_cfg[i+1][4:3] == A_TOR);
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_cfgWe[i]  = csr_wen && w_cfgSel && !r_cfg[i][7];
            w_addrWe[i] = csr_wen && w_addrSel[i] && !r_cfg[i][7] && !w_torLock[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_cfg[i]  <= '0;
                r_addr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (w_cfgWe[i]) begin
                    r_cfg[i] <= legalizeCfg(csr_wdata[8*i +: 8]);
                end
                if (w_addrWe[i]) begin
                    r_addr[i] <= csr_wdata[29:0];
                end
            end
        end
    end

    // Masks trail the architectural state by one cycle; pmp_stable flags that gap.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_mask[i] <= 32'h3;
            end
            r_stable <= 1'b1;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_mask[i] <= napotMask(r_addr[i][28:0], r_cfg[i][4:3] == A_NAPOT);
            end
            r_stable <= !((|w_cfgWe) || (|w_addrWe));
        end
    end

    always_comb begin
        w_readData = '0;
        if (w_cfgSel) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                w_readData[8*i +: 8] = r_cfg[i];
            end
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_addrSel[i]) begin
                w_readData = {2'b00, r_addr[i]};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= csr_ren;
            if (csr_ren) begin
                r_rdata <= w_readData;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            pmp_l[i]             = r_cfg[i][7];
            pmp_a[2*i +: 2]      = r_cfg[i][4:3];
            pmp_x[i]             = r_cfg[i][2];
            pmp_w[i]             = r_cfg[i][1];
            pmp_r[i]             = r_cfg[i][0];
            pmp_addr[30*i +: 30] = r_addr[i];
            pmp_mask[32*i +: 32] = r_mask[i];
        end
        csr_rvalid = r_rvalid;
        csr_rdata  = r_rdata;
        pmp_stable = r_stable;
    end
endmodule

// File: tb/tb_pmp_csr_regs.sv
// Scoreboard bench for pmp_csr_regs: stimulus pushes expected per-cycle outputs and
// read data from a field-level model; a monitor pops and compares after each edge.
module tb_pmp_csr_regs;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         csr_wen = 1'b0;
    logic         csr_ren = 1'b0;
    logic [11:0]  csr_addr = '0;
    logic [31:0]  csr_wdata = '0;
    logic         csr_hit;
    logic         csr_rvalid;
    logic [31:0]  csr_rdata;
    logic [3:0]   pmp_l;
    logic [7:0]   pmp_a;
    logic [3:0]   pmp_x;
    logic [3:0]   pmp_w;
    logic [3:0]   pmp_r;
    logic [119:0] pmp_addr;
    logic [127:0] pmp_mask;
    logic         pmp_stable;

    pmp_csr_regs dut (
        .clock(clock), .reset(reset), .csr_wen(csr_wen), .csr_ren(csr_ren),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_hit(csr_hit),
        .csr_rvalid(csr_rvalid), .csr_rdata(csr_rdata), .pmp_l(pmp_l), .pmp_a(pmp_a),
        .pmp_x(pmp_x), .pmp_w(pmp_w), .pmp_r(pmp_r), .pmp_addr(pmp_addr),
        .pmp_mask(pmp_mask), .pmp_stable(pmp_stable)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]   l, x, w, r;
        logic [7:0]   a;
        logic [119:0] addr;
        logic [127:0] mask;
        logic         stable;
        logic         rvalid;
    } snap_t;

    snap_t       snapQ[$];
    logic [31:0] readQ[$];
    int          nCompared = 0;
    int          nMismatch = 0;

    // Architectural model: one field per entry, mask as seen by the checker.
    bit        mL[4];
    bit [1:0]  mA[4];
    bit        mX[4], mW[4], mR[4];
    bit [29:0] mAddr[4];
    bit [31:0] mMask[4];

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatch++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Byte mask = 2 always-don't-care bits plus one bit per trailing one of {addr, napot}.
    function automatic bit [31:0] modelMask(input bit [29:0] addr, input bit napot);
        bit [30:0] t;
        int n;
        t = {addr, napot};
        n = 0;
        while (n < 31 && t[n]) n++;
        if (n >= 30) return 32'hFFFF_FFFF;
        return 32'((64'd1 << (n + 2)) - 64'd1);
    endfunction

    function automatic bit [31:0] modelRead(input logic [11:0] addr);
        bit [31:0] v;
        v = '0;
        if (addr == 12'h3A0) begin
            for (int i = 0; i < 4; i++) v[8*i +: 8] = {mL[i], 2'b00, mA[i], mX[i], mW[i], mR[i]};
        end else if (addr >= 12'h3B0 && addr <= 12'h3B3) begin
            v = {2'b00, mAddr[int'(addr - 12'h3B0)]};
        end
        return v;
    endfunction

    task automatic applyStimulus(input bit rst, input bit wen, input bit ren,
                                 input logic [11:0] addr, input logic [31:0] wdata);
        snap_t     s;
        bit        accepted;
        bit        hit;
        bit [31:0] nextMask[4];
        bit [7:0]  b;
        int        idx;
        @(negedge clock);
        reset     = rst;
        csr_wen   = wen;
        csr_ren   = ren;
        csr_addr  = addr;
        csr_wdata = wdata;
        hit = (addr == 12'h3A0) || (addr >= 12'h3B0 && addr <= 12'h3B3);
        accepted = 1'b0;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mL[i] = 0; mA[i] = 0; mX[i] = 0; mW[i] = 0; mR[i] = 0;
                mAddr[i] = '0;
                mMask[i] = 32'h3;
            end
        end else begin
            for (int i = 0; i < 4; i++) nextMask[i] = modelMask(mAddr[i], mA[i] == 2'd3);
            if (ren) readQ.push_back(modelRead(addr));
            if (wen && addr == 12'h3A0) begin
                for (int i = 0; i < 4; i++) begin
                    if (!mL[i]) begin
                        b = wdata[8*i +: 8];
                        mL[i] = b[7]; mA[i] = b[4:3]; mX[i] = b[2];
                        mR[i] = b[0]; mW[i] = b[1] && b[0];
                        accepted = 1'b1;
                    end
                end
            end else if (wen && hit) begin
                idx = int'(addr - 12'h3B0);
                if (!(mL[idx] || (idx < 3 && mL[idx+1] && mA[idx+1] == 2'd1))) begin
                    mAddr[idx] = wdata[29:0];
                    accepted = 1'b1;
                end
            end
            for (int i = 0; i < 4; i++) mMask[i] = nextMask[i];
        end
        for (int i = 0; i < 4; i++) begin
            s.l[i] = mL[i]; s.x[i] = mX[i]; s.w[i] = mW[i]; s.r[i] = mR[i];
            s.a[2*i +: 2]      = mA[i];
            s.addr[30*i +: 30] = mAddr[i];
            s.mask[32*i +: 32] = mMask[i];
        end
        s.stable = rst ? 1'b1 : !accepted;
        s.rvalid = rst ? 1'b0 : ren;
        snapQ.push_back(s);
        #1;
        checkOutput("csr_hit", csr_hit, hit);
    endtask

    initial begin
        snap_t e;
        forever begin
            @(posedge clock);
            #1;
            if (snapQ.size() > 0) begin
                e = snapQ.pop_front();
                checkOutput("pmp_l", pmp_l, e.l);
                checkOutput("pmp_a", pmp_a, e.a);
                checkOutput("pmp_x", pmp_x, e.x);
                checkOutput("pmp_w", pmp_w, e.w);
                checkOutput("pmp_r", pmp_r, e.r);
                checkOutput("pmp_addr", pmp_addr, e.addr);
                checkOutput("pmp_mask", pmp_mask, e.mask);
                checkOutput("pmp_stable", pmp_stable, e.stable);
                checkOutput("csr_rvalid", csr_rvalid, e.rvalid);
                if (csr_rvalid === 1'b1) begin
                    if (readQ.size() > 0) begin
                        checkOutput("csr_rdata", csr_rdata, readQ.pop_front());
                    end else begin
                        nCompared++;
                        nMismatch++;
                        $display("[TB] FAIL csr_rdata at %0t: rvalid with no read pending, got %h", $time, csr_rdata);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [11:0] addrPool[8] = '{12'h3A0, 12'h3B0, 12'h3B1, 12'h3B2, 12'h3B3, 12'h3A1, 12'h3B4, 12'h7C0};

    initial begin
        logic [11:0] a;
        logic [31:0] d;
        int          waitCycles;

        applyStimulus(1, 0, 0, 12'h000, 0);
        applyStimulus(1, 0, 0, 12'h000, 0);
        applyStimulus(0, 0, 1, 12'h3A0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 12'h3B0 + 12'(i), 0);

        applyStimulus(0, 1, 0, 12'h3B0, 32'h0000_0007);
        applyStimulus(0, 1, 0, 12'h3A0, 32'h0000_0018);
        repeat (3) applyStimulus(0, 0, 0, 12'h000, 0);

        applyStimulus(0, 1, 0, 12'h3A0, 32'h0000_0A00);
        applyStimulus(0, 0, 1, 12'h3A0, 0);
        applyStimulus(0, 0, 0, 12'h000, 0);

        applyStimulus(0, 1, 0, 12'h3A0, 32'h0000_8800);
        applyStimulus(0, 0, 0, 12'h000, 0);
        applyStimulus(0, 1, 0, 12'h3B0, 32'h0000_0123);
        applyStimulus(0, 0, 0, 12'h000, 0);
        applyStimulus(0, 1, 0, 12'h3B1, 32'h0000_0456);
        applyStimulus(0, 0, 0, 12'h000, 0);
        applyStimulus(0, 1, 0, 12'h3A0, 32'h0000_0000);
        applyStimulus(0, 0, 1, 12'h3A0, 0);
        applyStimulus(0, 0, 1, 12'h3B0, 0);
        applyStimulus(0, 0, 1, 12'h3B1, 0);

        applyStimulus(0, 1, 0, 12'h3B2, 32'h0000_0005);
        applyStimulus(0, 1, 1, 12'h3B2, 32'h0000_0ABC);
        applyStimulus(0, 0, 1, 12'h3B2, 0);

        applyStimulus(0, 1, 0, 12'h3A1, 32'hFFFF_FFFF);
        applyStimulus(0, 0, 1, 12'h3B4, 0);

        applyStimulus(0, 1, 0, 12'h3A0, 32'h0080_0000);
        applyStimulus(0, 1, 0, 12'h3B3, 32'h0000_00FF);
        applyStimulus(1, 0, 1, 12'h3B2, 0);
        applyStimulus(0, 1, 0, 12'h3B2, 32'h0000_0077);
        applyStimulus(0, 0, 1, 12'h3B2, 0);
        applyStimulus(0, 0, 0, 12'h000, 0);

        for (int n = 0; n < 600; n++) begin
            a = addrPool[$urandom_range(0, 7)];
            if (a == 12'h3A0) begin
                d = $urandom;
                if ($urandom_range(0, 5) != 0) d = d & 32'h7F7F_7F7F;
            end else if ($urandom_range(0, 1) == 1) begin
                d = (32'h1 << $urandom_range(0, 31)) - 32'h1;
            end else begin
                d = $urandom;
            end
            applyStimulus($urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 2) == 0, a, d);
        end

        applyStimulus(0, 0, 0, 12'h000, 0);
        applyStimulus(0, 0, 0, 12'h000, 0);
        waitCycles = 0;
        while (snapQ.size() > 0 && waitCycles < 10) begin
            @(negedge clock);
            waitCycles++;
        end
        checkOutput("snapshot_queue_drained", 128'(snapQ.size()), 128'd0);
        checkOutput("read_queue_drained", 128'(readQ.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
